csr_req_initiator: RTL and testbench

- CSR-manager initiator. Drives the csr_req/csr_rsp port of an accelerator wrapper from an upstream command stream.
- Upstream can be a host shim or test sequencer. It pushes {addr, wr_data, wr_en} commands.
- The block buffers the commands, issues them in order, and tracks outstanding reads with a credit counter.
- Read data returns in order on a valid-ready stream.

---
 rtl/csr_req_initiator.sv | 209 ++++++++++++++++++++
 tb/tb_csr_req_initiator.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_req_initiator.sv
// CSR-manager initiator: buffers upstream commands, issues them in order to a
// CSR target and returns read data in order, with credit-limited outstanding reads.
`timescale 1ns/1ps

module csr_req_initiator #(
  parameter int unsigned RegCount       = 8,
  parameter int unsigned RegDataWidth   = 32,
  parameter int unsigned RegAddrWidth   = $clog2(RegCount),
  parameter int unsigned CmdFifoDepth   = 4,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,

  input  logic [RegAddrWidth-1:0] cmd_addr_i,
  input  logic [RegDataWidth-1:0] cmd_wr_data_i,
  input  logic                    cmd_wr_en_i,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,

  output logic [RegDataWidth-1:0] rd_data_o,
  output logic                    rd_valid_o,
  input  logic                    rd_ready_i,

  output logic [RegAddrWidth-1:0] csr_addr_o,
  output logic [RegDataWidth-1:0] csr_wr_data_o,
  output logic                    csr_wr_en_o,
  output logic                    csr_req_valid_o,
  input  logic                    csr_req_ready_i,
  input  logic [RegDataWidth-1:0] csr_rd_data_i,
  input  logic                    csr_rsp_valid_i,
  output logic                    csr_rsp_ready_o,

  output logic                    busy_o,
  output logic                    err_o
);

  localparam int unsigned CmdPtrW = $clog2(CmdFifoDepth);
  localparam int unsigned CmdCntW = CmdPtrW + 1;
  localparam int unsigned OutCntW = $clog2(MaxOutstanding + 1);
  localparam int unsigned OccW    = OutCntW + 1;
  localparam int unsigned RspPtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

  typedef struct packed {
    logic [RegAddrWidth-1:0] addr;
    logic [RegDataWidth-1:0] wr_data;
    logic                    wr_en;
  } cmd_t;

  // Command FIFO state
  cmd_t               cmd_mem [CmdFifoDepth];
  logic [CmdPtrW-1:0] cmd_wr_ptr;
  logic [CmdPtrW-1:0] cmd_rd_ptr;
  logic [CmdCntW-1:0] cmd_cnt;
  logic               cmd_full;
  logic               cmd_empty;
  logic               cmd_push;
  logic               cmd_pop;
  cmd_t               cmd_in;
  cmd_t               cmd_head;

  // Read tracking and response buffer state
  logic [RegDataWidth-1:0] rsp_mem [MaxOutstanding];
  logic [RspPtrW-1:0]      rsp_wr_ptr;
  logic [RspPtrW-1:0]      rsp_rd_ptr;
  logic [OutCntW-1:0]      rsp_cnt;
  logic [OutCntW-1:0]      inflight;
  logic [OccW-1:0]         occupied;
  logic                    has_credit;
  logic                    rsp_full;
  logic                    rsp_empty;
  logic                    rsp_accept;
  logic                    rsp_push;
  logic                    rsp_spurious;
  logic                    rd_pop;
  logic                    rd_issue;
  logic                    err_q;

  // Response buffer depth need not be a power of two, so wrap explicitly.
  function automatic logic [RspPtrW-1:0] rsp_ptr_inc(input logic [RspPtrW-1:0] p);
    return (p == RspPtrW'(MaxOutstanding - 1)) ? '0 : p + RspPtrW'(1);
  endfunction

  // Command FIFO flags and handshakes
  always_comb begin
    cmd_full     = (cmd_cnt == CmdCntW'(CmdFifoDepth));
    cmd_empty    = (cmd_cnt == '0);
    cmd_in       = '{addr: cmd_addr_i, wr_data: cmd_wr_data_i, wr_en: cmd_wr_en_i};
    cmd_head     = cmd_mem[cmd_rd_ptr];
    cmd_push     = cmd_valid_i && !cmd_full;
    cmd_pop      = csr_req_valid_o && csr_req_ready_i;
    rd_issue     = cmd_pop && !cmd_head.wr_en;
  end

  // Credit gate from registered counts only, so no ready-to-valid path exists
  always_comb begin
    occupied   = OccW'(inflight) + OccW'(rsp_cnt);
    has_credit = (occupied < OccW'(MaxOutstanding));
  end

  // Response buffer flags and handshakes
  always_comb begin
    rsp_full     = (rsp_cnt == OutCntW'(MaxOutstanding));
    rsp_empty    = (rsp_cnt == '0);
    rsp_accept   = csr_rsp_valid_i && !rsp_full;
    rsp_push     = rsp_accept && (inflight != '0);
    rsp_spurious = rsp_accept && (inflight == '0);
    rd_pop       = !rsp_empty && rd_ready_i;
  end

  // Command storage; contents need no reset since occupancy is tracked separately
  always_ff @(posedge clk_i) begin
    if (cmd_push) begin
      cmd_mem[cmd_wr_ptr] <= cmd_in;
    end
  end

  // Command FIFO pointers and occupancy
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cmd_wr_ptr <= '0;
      cmd_rd_ptr <= '0;
      cmd_cnt    <= '0;
    end else begin
      if (cmd_push) begin
        cmd_wr_ptr <= cmd_wr_ptr + CmdPtrW'(1);
      end
      if (cmd_pop) begin
        cmd_rd_ptr <= cmd_rd_ptr + CmdPtrW'(1);
      end
      if (cmd_push && !cmd_pop) begin
        cmd_cnt <= cmd_cnt + CmdCntW'(1);
      end else if (!cmd_push && cmd_pop) begin
        cmd_cnt <= cmd_cnt - CmdCntW'(1);
      end
    end
  end

  // Read data storage
  always_ff @(posedge clk_i) begin
    if (rsp_push) begin
      rsp_mem[rsp_wr_ptr] <= csr_rd_data_i;
    end
  end

  // Response buffer pointers and occupancy
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_wr_ptr <= '0;
      rsp_rd_ptr <= '0;
      rsp_cnt    <= '0;
    end else begin
      if (rsp_push) begin
        rsp_wr_ptr <= rsp_ptr_inc(rsp_wr_ptr);
      end
      if (rd_pop) begin
        rsp_rd_ptr <= rsp_ptr_inc(rsp_rd_ptr);
      end
      if (rsp_push && !rd_pop) begin
        rsp_cnt <= rsp_cnt + OutCntW'(1);
      end else if (!rsp_push && rd_pop) begin
        rsp_cnt <= rsp_cnt - OutCntW'(1);
      end
    end
  end

  // Reads in flight: up on issue, down when the matching response is buffered
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      inflight <= '0;
    end else if (rd_issue && !rsp_push) begin
      inflight <= inflight + OutCntW'(1);
    end else if (!rd_issue && rsp_push) begin
      inflight <= inflight - OutCntW'(1);
    end
  end

  // Sticky flag for a response that no outstanding read can own
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else if (rsp_spurious) begin
      err_q <= 1'b1;
    end
  end

  // Output drive: request mirrors the FIFO head, read data mirrors the buffer head
  always_comb begin
    cmd_ready_o     = !cmd_full;
    csr_addr_o      = cmd_head.addr;
    csr_wr_data_o   = cmd_head.wr_data;
    csr_wr_en_o     = cmd_head.wr_en;
    csr_req_valid_o = !cmd_empty && (cmd_head.wr_en || has_credit);
    csr_rsp_ready_o = !rsp_full;
    rd_data_o       = rsp_mem[rsp_rd_ptr];
    rd_valid_o      = !rsp_empty;
    busy_o          = !cmd_empty || (inflight != '0) || !rsp_empty;
    err_o           = err_q;
  end

  // Credit accounting never exceeds the outstanding limit
  a_no_overcommit: assert property (@(posedge clk_i) disable iff (!rst_ni)
    occupied <= OccW'(MaxOutstanding));

  // A stalled request keeps valid and its fields until accepted
  a_req_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (csr_req_valid_o && !csr_req_ready_i) |=> (csr_req_valid_o && $stable(cmd_head)));

endmodule

// File: tb/tb_csr_req_initiator.sv
// Directed bench for csr_req_initiator with a queue-level reference model
// and a behavioural CSR target.
`timescale 1ns/1ps

module tb_csr_req_initiator;

  localparam int AW    = 3;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int MAXO  = 2;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wr_data;
  logic          cmd_wr_en;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          rd_ready;
  logic [AW-1:0] csr_addr;
  logic [DW-1:0] csr_wr_data;
  logic          csr_wr_en;
  logic          csr_req_valid;
  logic          csr_req_ready;
  logic [DW-1:0] csr_rd_data;
  logic          csr_rsp_valid;
  logic          csr_rsp_ready;
  logic          busy;
  logic          err;

  csr_req_initiator dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .cmd_addr_i      (cmd_addr),
    .cmd_wr_data_i   (cmd_wr_data),
    .cmd_wr_en_i     (cmd_wr_en),
    .cmd_valid_i     (cmd_valid),
    .cmd_ready_o     (cmd_ready),
    .rd_data_o       (rd_data),
    .rd_valid_o      (rd_valid),
    .rd_ready_i      (rd_ready),
    .csr_addr_o      (csr_addr),
    .csr_wr_data_o   (csr_wr_data),
    .csr_wr_en_o     (csr_wr_en),
    .csr_req_valid_o (csr_req_valid),
    .csr_req_ready_i (csr_req_ready),
    .csr_rd_data_i   (csr_rd_data),
    .csr_rsp_valid_i (csr_rsp_valid),
    .csr_rsp_ready_o (csr_rsp_ready),
    .busy_o          (busy),
    .err_o           (err)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model: queues of commands and read data ----------------
  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          wr;
  } mcmd_t;

  mcmd_t         mq[$];
  logic [DW-1:0] mrq[$];
  int            minf = 0;
  logic          merr = 1'b0;

  function automatic logic m_req_valid();
    if (mq.size() == 0) return 1'b0;
    return mq[0].wr || ((minf + mrq.size()) < MAXO);
  endfunction

  // Advance the model by one clock using the inputs presented this cycle
  always @(posedge clk or negedge rst_n) begin : model
    logic  push, issue, acc, pop;
    int    inf0;
    mcmd_t c;
    if (!rst_n) begin
      mq.delete();
      mrq.delete();
      minf = 0;
      merr = 1'b0;
    end else begin
      push  = cmd_valid && (mq.size() < DEPTH);
      issue = m_req_valid() && csr_req_ready;
      acc   = csr_rsp_valid && (mrq.size() < MAXO);
      pop   = (mrq.size() > 0) && rd_ready;
      inf0  = minf;
      if (pop) void'(mrq.pop_front());
      if (issue) begin
        c = mq.pop_front();
        if (!c.wr) minf++;
      end
      if (acc) begin
        if (inf0 > 0) begin
          mrq.push_back(csr_rd_data);
          minf--;
        end else begin
          merr = 1'b1;
        end
      end
      if (push) begin
        c.addr = cmd_addr;
        c.data = cmd_wr_data;
        c.wr   = cmd_wr_en;
        mq.push_back(c);
      end
    end
  end

  // Compare DUT outputs against the model mid-cycle
  always @(negedge clk) begin : compare
    check("cmd_ready", 32'(cmd_ready), 32'(mq.size() < DEPTH));
    check("req_valid", 32'(csr_req_valid), 32'(m_req_valid()));
    if (mq.size() > 0) begin
      check("req_addr", 32'(csr_addr), 32'(mq[0].addr));
      check("req_data", csr_wr_data, mq[0].data);
      check("req_wr_en", 32'(csr_wr_en), 32'(mq[0].wr));
    end
    check("rsp_ready", 32'(csr_rsp_ready), 32'(mrq.size() < MAXO));
    check("rd_valid", 32'(rd_valid), 32'(mrq.size() > 0));
    if (mrq.size() > 0) check("rd_data", rd_data, mrq[0]);
    check("busy", 32'(busy), 32'((mq.size() > 0) || (minf != 0) || (mrq.size() > 0)));
    check("err", 32'(err), 32'(merr));
  end

  // ---------------- behavioural CSR target ----------------
  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } pend_t;

  logic [DW-1:0] tregs [8];
  pend_t         pend[$];
  int            ecnt      = 0;
  int            rsp_delay = 1;
  int            spur_req  = 0;
  int            spur_done = 0;
  logic          cur_spur  = 1'b0;

  initial begin : target
    pend_t p;
    csr_rsp_valid = 1'b0;
    csr_rd_data   = '0;
    for (int i = 0; i < 8; i++) tregs[i] = 32'h5500_0000 + 32'(i);
    tregs[5] = 32'hDEAD_BEEF;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend.delete();
      end else begin
        if (csr_rsp_valid && csr_rsp_ready && !cur_spur) void'(pend.pop_front());
        if (csr_req_valid && csr_req_ready) begin
          if (csr_wr_en) begin
            tregs[csr_addr] = csr_wr_data;
          end else begin
            p.data = tregs[csr_addr];
            p.due  = ecnt + 1 + rsp_delay;
            pend.push_back(p);
          end
        end
      end
      @(posedge clk);
      ecnt++;
      #1;
      csr_rsp_valid = 1'b0;
      cur_spur      = 1'b0;
      if (rst_n) begin
        if (pend.size() > 0 && pend[0].due <= ecnt) begin
          csr_rsp_valid = 1'b1;
          csr_rd_data   = pend[0].data;
        end else if (pend.size() == 0 && spur_req != spur_done) begin
          csr_rsp_valid = 1'b1;
          csr_rd_data   = 32'h0000_1234;
          cur_spur      = 1'b1;
          spur_done++;
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic send(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic wr);
    cmd_valid   = 1'b1;
    cmd_addr    = a;
    cmd_wr_data = d;
    cmd_wr_en   = wr;
    step();
    cmd_valid   = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int max_cyc);
    int n = 0;
    while (busy && n < max_cyc) begin
      step();
      n++;
    end
    check(name, 32'(busy), 32'(0));
  endtask

  task automatic wait_rd(input string name, output int n);
    n = 0;
    while (!rd_valid && n < 30) begin
      step();
      n++;
    end
    check(name, 32'(rd_valid), 32'(1));
  endtask

  initial begin : stim
    int lat;
    int seen;
    cmd_valid     = 1'b0;
    cmd_addr      = '0;
    cmd_wr_data   = '0;
    cmd_wr_en     = 1'b0;
    rd_ready      = 1'b1;
    csr_req_ready = 1'b1;
    step();
    step();
    check("rst_cmd_ready", 32'(cmd_ready), 32'(1));
    check("rst_req_valid", 32'(csr_req_valid), 32'(0));
    check("rst_rsp_ready", 32'(csr_rsp_ready), 32'(1));
    check("rst_busy", 32'(busy), 32'(0));
    rst_n = 1'b1;
    step();

    // Write burst addr 0..3, data A0..A3
    cmd_valid = 1'b1;
    cmd_wr_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cmd_addr    = AW'(i);
      cmd_wr_data = 32'hA0 + 32'(i);
      step();
    end
    cmd_valid = 1'b0;
    check("burst_last_addr", 32'(csr_addr), 32'(3));
    check("burst_last_data", csr_wr_data, 32'hA3);
    check("burst_last_valid", 32'(csr_req_valid), 32'(1));
    check("burst_no_rd", 32'(rd_valid), 32'(0));
    step();
    check("burst_idle", 32'(busy), 32'(0));

    // Single read of addr 5, response two cycles after the request
    send(3'd5, '0, 1'b0);
    wait_rd("single_rd_wait", lat);
    check("single_rd_latency", 32'(lat), 32'(3));
    check("single_rd_data", rd_data, 32'hDEAD_BEEF);
    step();
    check("single_rd_drained", 32'(rd_valid), 32'(0));
    check("single_rd_idle", 32'(busy), 32'(0));

    // Credit stall: three reads, no read-data drain
    rd_ready = 1'b0;
    send(3'd0, '0, 1'b0);
    send(3'd1, '0, 1'b0);
    send(3'd2, '0, 1'b0);
    repeat (6) step();
    check("stall_req_blocked", 32'(csr_req_valid), 32'(0));
    check("stall_head_addr", 32'(csr_addr), 32'(2));
    check("stall_rd_data", rd_data, 32'hA0);
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
    check("stall_release_valid", 32'(csr_req_valid), 32'(1));
    check("stall_release_addr", 32'(csr_addr), 32'(2));
    check("stall_next_rd", rd_data, 32'hA1);
    rd_ready = 1'b1;
    wait_idle("stall_drain", 40);

    // Backpressure with a full FIFO
    csr_req_ready = 1'b0;
    cmd_valid     = 1'b1;
    cmd_wr_en     = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cmd_addr    = AW'(4 + i);
      cmd_wr_data = 32'hB4 + 32'(i);
      step();
    end
    cmd_addr    = 3'd0;
    cmd_wr_data = 32'hFF;
    for (int i = 0; i < 6; i++) begin
      step();
      check("bp_cmd_ready", 32'(cmd_ready), 32'(0));
      check("bp_addr_stable", 32'(csr_addr), 32'(4));
      check("bp_data_stable", csr_wr_data, 32'hB4);
    end
    cmd_valid     = 1'b0;
    csr_req_ready = 1'b1;
    wait_idle("bp_drain", 20);
    send(3'd6, '0, 1'b0);
    wait_rd("bp_readback_wait", lat);
    check("bp_readback", rd_data, 32'hB6);
    wait_idle("bp_readback_idle", 20);

    // Spurious response with nothing in flight
    spur_req++;
    repeat (3) step();
    check("spur_err", 32'(err), 32'(1));
    check("spur_no_rd", 32'(rd_valid), 32'(0));
    send(3'd2, '0, 1'b0);
    wait_rd("post_spur_wait", lat);
    check("post_spur_data", rd_data, 32'hA2);
    check("err_sticky", 32'(err), 32'(1));
    wait_idle("post_spur_idle", 20);

    // Reset with two reads in flight and three commands queued
    rsp_delay = 30;
    send(3'd0, '0, 1'b0);
    send(3'd1, '0, 1'b0);
    send(3'd2, '0, 1'b0);
    send(3'd6, 32'hC6, 1'b1);
    send(3'd7, 32'hC7, 1'b1);
    check("pre_rst_busy", 32'(busy), 32'(1));
    check("pre_rst_blocked", 32'(csr_req_valid), 32'(0));
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_cmd_ready", 32'(cmd_ready), 32'(1));
    check("async_rst_req_valid", 32'(csr_req_valid), 32'(0));
    check("async_rst_rd_valid", 32'(rd_valid), 32'(0));
    check("async_rst_rsp_ready", 32'(csr_rsp_ready), 32'(1));
    check("async_rst_busy", 32'(busy), 32'(0));
    check("async_rst_err", 32'(err), 32'(0));
    step();
    step();
    rst_n     = 1'b1;
    rsp_delay = 1;
    seen      = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (csr_req_valid) seen++;
    end
    check("no_replay", 32'(seen), 32'(0));
    check("post_rst_idle", 32'(busy), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
